// File: rtl/instr_encoder_loader_pkg.sv
// Shared constants and types for the RV32I instruction encoder/loader.
// The opcode values are the ones the main control decoder matches against.
package instr_encoder_loader_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [2:0] {
    CLS_LOAD   = 3'd0,
    CLS_IMM    = 3'd1,
    CLS_STORE  = 3'd2,
    CLS_RTYPE  = 3'd3,
    CLS_BRANCH = 3'd4
  } instr_cls_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE,
    ST_FAULT
  } load_state_e;

  // funct7 as used by R-type and shift-immediate: only bit 30 is ever set
  function automatic logic [6:0] funct7_of(input logic f7_5);
    return {1'b0, f7_5, 5'b00000};
  endfunction

endpackage

// File: rtl/instr_encoder_loader_if.sv
// Bundles the field stream, instruction-memory write port and status of the loader.
// master = program source / memory side, slave = the loader itself.
interface instr_encoder_loader_if #(
  parameter int ADDR_WIDTH = 8
);
  logic                  Start;
  logic                  In_Valid;
  logic                  In_Ready;
  logic                  In_Last;
  logic [2:0]            Instr_Class;
  logic [4:0]            Rd;
  logic [4:0]            Rs1;
  logic [4:0]            Rs2;
  logic [2:0]            Funct3;
  logic                  Funct7_5;
  logic [12:0]           Imm;
  logic                  Mem_Ready;
  logic                  Mem_We;
  logic [ADDR_WIDTH-1:0] Mem_Addr;
  logic [31:0]           Mem_Wdata;
  logic                  Core_Hold;
  logic                  Done;
  logic                  Error;
  logic [ADDR_WIDTH:0]   Word_Count;

  modport master (
    output Start, In_Valid, In_Last, Instr_Class, Rd, Rs1, Rs2, Funct3, Funct7_5, Imm,
    output Mem_Ready,
    input  In_Ready, Mem_We, Mem_Addr, Mem_Wdata, Core_Hold, Done, Error, Word_Count
  );

  modport slave (
    input  Start, In_Valid, In_Last, Instr_Class, Rd, Rs1, Rs2, Funct3, Funct7_5, Imm,
    input  Mem_Ready,
    output In_Ready, Mem_We, Mem_Addr, Mem_Wdata, Core_Hold, Done, Error, Word_Count
  );
endinterface

// File: rtl/instr_encoder_loader_packer.sv
// Purely combinational packing of decoded fields into one RV32I word.
// legal_o is low for unknown classes and for branches with an odd offset.
module instr_field_packer
  import instr_encoder_loader_pkg::*;
(
  input  logic [2:0]  cls_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [2:0]  funct3_i,
  input  logic        funct7_5_i,
  input  logic [12:0] imm_i,
  output logic [31:0] word_o,
  output logic        legal_o
);

  always_comb begin
    word_o  = 32'h0;
    legal_o = 1'b1;
    case (instr_cls_e'(cls_i))
      CLS_LOAD:  word_o = {imm_i[11:0], rs1_i, funct3_i, rd_i, OP_LOAD};
      CLS_IMM: begin
        // slli/srli/srai carry a 5-bit shamt and funct7 in the upper immediate
        if (funct3_i == 3'b001 || funct3_i == 3'b101)
          word_o = {funct7_of(funct7_5_i), imm_i[4:0], rs1_i, funct3_i, rd_i, OP_IMM};
        else
          word_o = {imm_i[11:0], rs1_i, funct3_i, rd_i, OP_IMM};
      end
      CLS_STORE: word_o = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], OP_STORE};
      CLS_RTYPE: word_o = {funct7_of(funct7_5_i), rs2_i, rs1_i, funct3_i, rd_i, OP_RTYPE};
      CLS_BRANCH: begin
        word_o  = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i, imm_i[4:1], imm_i[11], OP_BRANCH};
        legal_o = ~imm_i[0];
      end
      default:   legal_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/instr_encoder_loader.sv
// Program loader: encodes a stream of instruction fields and writes the words
// sequentially into instruction memory while holding the core in reset.
module instr_encoder_loader
  import instr_encoder_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int BASE_ADDR  = 0
) (
  input logic                   clk,
  input logic                   rst,
  instr_encoder_loader_if.slave bus
);

  localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);

  load_state_e           state_q, state_d;
  logic                  out_valid_q, out_valid_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  error_q, error_d;

  logic [31:0] packed_word;
  logic        packed_legal;
  logic        in_ready, accept, write_done, overflow, can_start;

  instr_field_packer u_packer (
    .cls_i      (bus.Instr_Class),
    .rd_i       (bus.Rd),
    .rs1_i      (bus.Rs1),
    .rs2_i      (bus.Rs2),
    .funct3_i   (bus.Funct3),
    .funct7_5_i (bus.Funct7_5),
    .imm_i      (bus.Imm),
    .word_o     (packed_word),
    .legal_o    (packed_legal)
  );

  assign in_ready   = (state_q == ST_RUN) && (!out_valid_q || bus.Mem_Ready);
  assign accept     = bus.In_Valid && in_ready;
  assign write_done = out_valid_q && bus.Mem_Ready;
  // Still in RUN means In_Last has not been seen, so more words would follow
  assign overflow   = write_done && (addr_q == '1) && (state_q == ST_RUN);
  assign can_start  = (state_q == ST_IDLE) || (state_q == ST_DONE) || (state_q == ST_FAULT);

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    wdata_d     = wdata_q;
    addr_d      = addr_q;
    count_d     = count_q;
    error_d     = error_q;

    if (write_done) begin
      addr_d      = addr_q + 1'b1;
      count_d     = count_q + 1'b1;
      out_valid_d = 1'b0;
    end

    if (accept) begin
      if (packed_legal) begin
        out_valid_d = 1'b1;
        wdata_d     = packed_word;
      end else begin
        error_d = 1'b1;
      end
      if (bus.In_Last) state_d = ST_DRAIN;
    end

    if (overflow) begin
      error_d     = 1'b1;
      out_valid_d = 1'b0;
      state_d     = ST_FAULT;
    end

    if (state_q == ST_DRAIN && !out_valid_q) state_d = ST_DONE;

    if (can_start && bus.Start) begin
      state_d     = ST_RUN;
      out_valid_d = 1'b0;
      addr_d      = BASE;
      count_d     = '0;
      error_d     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      wdata_q     <= 32'h0;
      addr_q      <= BASE;
      count_q     <= '0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      wdata_q     <= wdata_d;
      addr_q      <= addr_d;
      count_q     <= count_d;
      error_q     <= error_d;
    end
  end

  assign bus.In_Ready   = in_ready;
  assign bus.Mem_We     = out_valid_q;
  assign bus.Mem_Addr   = addr_q;
  assign bus.Mem_Wdata  = wdata_q;
  assign bus.Core_Hold  = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign bus.Done       = (state_q == ST_DONE);
  assign bus.Error      = error_q;
  assign bus.Word_Count = count_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Scoreboard bench: dut1 uses the default 256-word memory, dut2 a 4-word memory
// for the overflow scenario. Expected writes are queued as fields are sent.
module tb_instr_encoder_loader;

  typedef struct {int addr; logic [31:0] data;} exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  instr_encoder_loader_if #(.ADDR_WIDTH(8)) bus ();
  instr_encoder_loader_if #(.ADDR_WIDTH(2)) bus2 ();

  instr_encoder_loader #(.ADDR_WIDTH(8), .BASE_ADDR(0)) dut1 (.clk(clk), .rst(rst_n), .bus(bus));
  instr_encoder_loader #(.ADDR_WIDTH(2), .BASE_ADDR(0)) dut2 (.clk(clk), .rst(rst_n), .bus(bus2));

  bit          sel = 1'b0;
  logic        f_start = 1'b0, f_valid = 1'b0, f_last = 1'b0, f_f75 = 1'b0, mem_ready = 1'b1;
  logic [2:0]  f_cls = '0, f_f3 = '0;
  logic [4:0]  f_rd = '0, f_rs1 = '0, f_rs2 = '0;
  logic [12:0] f_imm = '0;

  assign bus.Start = f_start && !sel;     assign bus2.Start = f_start && sel;
  assign bus.In_Valid = f_valid && !sel;  assign bus2.In_Valid = f_valid && sel;
  assign bus.In_Last = f_last;            assign bus2.In_Last = f_last;
  assign bus.Instr_Class = f_cls;         assign bus2.Instr_Class = f_cls;
  assign bus.Rd = f_rd;                   assign bus2.Rd = f_rd;
  assign bus.Rs1 = f_rs1;                 assign bus2.Rs1 = f_rs1;
  assign bus.Rs2 = f_rs2;                 assign bus2.Rs2 = f_rs2;
  assign bus.Funct3 = f_f3;               assign bus2.Funct3 = f_f3;
  assign bus.Funct7_5 = f_f75;            assign bus2.Funct7_5 = f_f75;
  assign bus.Imm = f_imm;                 assign bus2.Imm = f_imm;
  assign bus.Mem_Ready = mem_ready;       assign bus2.Mem_Ready = mem_ready;

  int   chk_cnt = 0, pass_cnt = 0;
  int   writes1 = 0, writes2 = 0;
  exp_t q1[$], q2[$];

  // Write monitors: a write completes at the next posedge when We && Ready at negedge
  always @(negedge clk) begin
    if (rst_n && bus.Mem_We && bus.Mem_Ready) begin
      exp_t e;
      writes1++;
      $display("dut1 write addr=%0d data=%08h", bus.Mem_Addr, bus.Mem_Wdata);
      chk_cnt++;
      if (q1.size() == 0) $display("FAIL dut1_unexpected_write got addr=%0d data=%08h, expected none", bus.Mem_Addr, bus.Mem_Wdata);
      else begin
        e = q1.pop_front();
        if (bus.Mem_Wdata !== e.data || int'(bus.Mem_Addr) != e.addr)
          $display("FAIL dut1_write got addr=%0d data=%08h, expected addr=%0d data=%08h", bus.Mem_Addr, bus.Mem_Wdata, e.addr, e.data);
        else pass_cnt++;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && bus2.Mem_We && bus2.Mem_Ready) begin
      exp_t e;
      writes2++;
      $display("dut2 write addr=%0d data=%08h", bus2.Mem_Addr, bus2.Mem_Wdata);
      chk_cnt++;
      if (q2.size() == 0) $display("FAIL dut2_unexpected_write got addr=%0d data=%08h, expected none", bus2.Mem_Addr, bus2.Mem_Wdata);
      else begin
        e = q2.pop_front();
        if (bus2.Mem_Wdata !== e.data || int'(bus2.Mem_Addr) != e.addr)
          $display("FAIL dut2_write got addr=%0d data=%08h, expected addr=%0d data=%08h", bus2.Mem_Addr, bus2.Mem_Wdata, e.addr, e.data);
        else pass_cnt++;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_session(input bit s);
    sel = s; f_start = 1'b1;
    tick(1);
    f_start = 1'b0;
  endtask

  task automatic push(input bit s, input int addr, input logic [31:0] data);
    exp_t e;
    e.addr = addr; e.data = data;
    if (s) q2.push_back(e); else q1.push_back(e);
  endtask

  // Present one set of fields until accepted (bounded); returns cycles spent waiting
  task automatic send(input logic [2:0] cls, input logic [4:0] rd, rs1, rs2, input logic [2:0] f3,
                      input logic f75, input logic [12:0] imm, input bit last, input bit must, output int waits);
    logic rdy;
    f_cls = cls; f_rd = rd; f_rs1 = rs1; f_rs2 = rs2; f_f3 = f3; f_f75 = f75; f_imm = imm;
    f_last = last; f_valid = 1'b1; waits = 0;
    while (1) begin
      @(negedge clk);
      rdy = sel ? bus2.In_Ready : bus.In_Ready;
      if (rdy || waits >= 40) break;
      waits++;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    f_valid = 1'b0; f_last = 1'b0;
    if (must) begin
      chk_cnt++;
      if (!rdy) $display("FAIL accept_timeout got In_Ready=0 for %0d cycles, expected acceptance", waits);
      else pass_cnt++;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk_cnt++;
    if ({bus.In_Ready, bus.Mem_We, bus.Core_Hold, bus.Done, bus.Error} !== 5'b0 || bus.Mem_Addr !== 8'd0 ||
        bus.Mem_Wdata !== 32'h0 || bus.Word_Count !== 9'd0)
      $display("FAIL %s got rdy=%b we=%b hold=%b done=%b err=%b addr=%0d wdata=%08h cnt=%0d, expected all zero",
               tag, bus.In_Ready, bus.Mem_We, bus.Core_Hold, bus.Done, bus.Error, bus.Mem_Addr, bus.Mem_Wdata, bus.Word_Count);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(2);
    check_reset_outputs("reset_values");
    rst_n = 1'b1;
    tick(1);
    check_reset_outputs("idle_after_reset");
  endtask

  task automatic test_single_imm();
    int w;
    start_session(0);
    chk_cnt++;
    if (bus.Core_Hold !== 1'b1) $display("FAIL hold_in_run got %b, expected 1", bus.Core_Hold); else pass_cnt++;
    push(0, 0, 32'h00500093);
    send(3'd1, 5'd1, 5'd0, 5'd0, 3'b000, 1'b0, 13'd5, 1'b1, 1'b1, w);
    tick(3);
    chk_cnt++;
    if (bus.Word_Count !== 9'd1) $display("FAIL single_count got %0d, expected 1", bus.Word_Count); else pass_cnt++;
    chk_cnt++;
    if (bus.Done !== 1'b1) $display("FAIL single_done got %b, expected 1", bus.Done); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int w, wsum;
    start_session(0);
    chk_cnt++;
    if (bus.Done !== 1'b0 || bus.Word_Count !== 9'd0) $display("FAIL restart_clear got done=%b cnt=%0d, expected 0/0", bus.Done, bus.Word_Count);
    else pass_cnt++;
    mem_ready = 1'b1; wsum = 0;
    push(0, 0, 32'h0080A103); send(3'd0, 5'd2, 5'd1, 5'd0, 3'b010, 1'b0, 13'd8,  1'b0, 1'b1, w); wsum += w;
    push(0, 1, 32'h0020A623); send(3'd2, 5'd0, 5'd1, 5'd2, 3'b010, 1'b0, 13'd12, 1'b0, 1'b1, w); wsum += w;
    push(0, 2, 32'h402081B3); send(3'd3, 5'd3, 5'd1, 5'd2, 3'b000, 1'b1, 13'd0,  1'b0, 1'b1, w); wsum += w;
    push(0, 3, 32'hFE208EE3); send(3'd4, 5'd0, 5'd1, 5'd2, 3'b000, 1'b0, 13'h1FFC, 1'b1, 1'b1, w); wsum += w;
    chk_cnt++;
    if (wsum != 0) $display("FAIL b2b_throughput got %0d stall cycles, expected 0", wsum); else pass_cnt++;
    tick(3);
    chk_cnt++;
    if (bus.Done !== 1'b1 || bus.Core_Hold !== 1'b0 || bus.Word_Count !== 9'd4)
      $display("FAIL b2b_done got done=%b hold=%b cnt=%0d, expected 1/0/4", bus.Done, bus.Core_Hold, bus.Word_Count);
    else pass_cnt++;
  endtask

  task automatic test_stall();
    int w, base_writes;
    start_session(0);
    mem_ready = 1'b0;
    push(0, 0, 32'h00700293);
    send(3'd1, 5'd5, 5'd0, 5'd0, 3'b000, 1'b0, 13'd7, 1'b0, 1'b1, w);
    base_writes = writes1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_cnt++;
      if (bus.Mem_We !== 1'b1 || bus.Mem_Wdata !== 32'h00700293 || bus.Mem_Addr !== 8'd0 || bus.In_Ready !== 1'b0)
        $display("FAIL stall_hold cyc%0d got we=%b data=%08h addr=%0d rdy=%b, expected 1/00700293/0/0",
                 i, bus.Mem_We, bus.Mem_Wdata, bus.Mem_Addr, bus.In_Ready);
      else pass_cnt++;
      @(posedge clk); #1;
    end
    mem_ready = 1'b1;
    tick(3);
    chk_cnt++;
    if (writes1 - base_writes != 1) $display("FAIL stall_one_write got %0d writes, expected 1", writes1 - base_writes); else pass_cnt++;
    push(0, 1, 32'h00100313);
    send(3'd1, 5'd6, 5'd0, 5'd0, 3'b000, 1'b0, 13'd1, 1'b1, 1'b1, w);
    tick(3);
    chk_cnt++;
    if (bus.Done !== 1'b1 || bus.Word_Count !== 9'd2) $display("FAIL stall_done got done=%b cnt=%0d, expected 1/2", bus.Done, bus.Word_Count);
    else pass_cnt++;
  endtask

  task automatic test_illegal();
    int w, base_writes;
    start_session(0);
    chk_cnt++;
    if (bus.Error !== 1'b0) $display("FAIL start_clears_error got %b, expected 0", bus.Error); else pass_cnt++;
    base_writes = writes1;
    send(3'd6, 5'd1, 5'd1, 5'd1, 3'b000, 1'b0, 13'd0, 1'b0, 1'b1, w);
    chk_cnt++;
    if (bus.Error !== 1'b1) $display("FAIL illegal_class_error got %b, expected 1", bus.Error); else pass_cnt++;
    send(3'd4, 5'd0, 5'd1, 5'd2, 3'b000, 1'b0, 13'd3, 1'b0, 1'b1, w);
    tick(2);
    chk_cnt++;
    if (bus.Error !== 1'b1 || bus.Word_Count !== 9'd0 || bus.Mem_We !== 1'b0 || writes1 != base_writes)
      $display("FAIL illegal_dropped got err=%b cnt=%0d we=%b writes=%0d, expected 1/0/0/0",
               bus.Error, bus.Word_Count, bus.Mem_We, writes1 - base_writes);
    else pass_cnt++;
    push(0, 0, 32'h00200393);
    send(3'd1, 5'd7, 5'd0, 5'd0, 3'b000, 1'b0, 13'd2, 1'b1, 1'b1, w);
    tick(3);
    chk_cnt++;
    if (bus.Done !== 1'b1 || bus.Error !== 1'b1 || bus.Word_Count !== 9'd1)
      $display("FAIL illegal_then_legal got done=%b err=%b cnt=%0d, expected 1/1/1", bus.Done, bus.Error, bus.Word_Count);
    else pass_cnt++;
  endtask

  task automatic test_overflow();
    int w;
    start_session(1);
    mem_ready = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      if (i <= 4) push(1, i - 1, (32'(i) << 20) | 32'h00000093);
      send(3'd1, 5'd1, 5'd0, 5'd0, 3'b000, 1'b0, 13'(i), (i == 5), (i <= 4), w);
    end
    tick(3);
    chk_cnt++;
    if (writes2 != 4) $display("FAIL overflow_writes got %0d, expected 4", writes2); else pass_cnt++;
    chk_cnt++;
    if (bus2.Error !== 1'b1 || bus2.Done !== 1'b0 || bus2.Core_Hold !== 1'b0 || bus2.In_Ready !== 1'b0 || bus2.Word_Count !== 3'd4)
      $display("FAIL overflow_fault got err=%b done=%b hold=%b rdy=%b cnt=%0d, expected 1/0/0/0/4",
               bus2.Error, bus2.Done, bus2.Core_Hold, bus2.In_Ready, bus2.Word_Count);
    else pass_cnt++;
    sel = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    int w, base_writes;
    start_session(0);
    mem_ready = 1'b0;
    send(3'd1, 5'd9, 5'd0, 5'd0, 3'b000, 1'b0, 13'd9, 1'b0, 1'b1, w);
    chk_cnt++;
    if (bus.Mem_We !== 1'b1) $display("FAIL pre_reset_pending got we=%b, expected 1", bus.Mem_We); else pass_cnt++;
    base_writes = writes1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_reset_mid_run");
    mem_ready = 1'b1;
    tick(2);
    rst_n = 1'b1;
    tick(5);
    chk_cnt++;
    if (writes1 != base_writes) $display("FAIL abandoned_session got %0d writes, expected 0", writes1 - base_writes); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_single_imm();
    test_back_to_back();
    test_stall();
    test_illegal();
    test_overflow();
    test_reset_mid_run();
    chk_cnt++;
    if (q1.size() != 0 || q2.size() != 0) $display("FAIL scoreboard_drained got %0d/%0d pending, expected 0/0", q1.size(), q2.size());
    else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got no finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
